lcd_nibble_receiver: RTL and testbench

Behavioural receiver for the 4-bit HD44780-style character-LCD bus that the `alu4` display path drives. It synchronises the bus onto `clk`, detects E falling edges, and tracks the 8-bit init phase before switching to 4-bit nibble pairing. It decodes commands and writes characters into a DDRAM-style port, giving the bench and the board-side monitor a cycle-accurate view of what the display would show.

---
 rtl/lcd_nibble_receiver.sv | 151 +++++++++++++++
 tb/tb_lcd_nibble_receiver.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver: HD44780-style 4-bit LCD bus receiver with command decode and DDRAM write port
//   clk, rst_n (async, active-low)       : clock and reset
//   e, rs, rw, db[3:0]                   : raw LCD bus; e is asynchronous to clk
//   byte_valid, byte_out[7:0], byte_rs   : decoded byte pulse, byte, and its register select
//   mem_we, mem_addr[6:0], mem_data[7:0] : DDRAM write strobe, address, character
//   mode4, disp_on, cursor_on, blink_on  : interface mode and display-control state
//   inc_mode, busy, err                  : entry direction, busy counter active, sticky protocol error
module lcd_nibble_receiver #(
    parameter int CLEAR_CYCLES = 82000,
    parameter int CMD_CYCLES   = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [3:0] db,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic       mem_we,
    output logic [6:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mode4,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       busy,
    output logic       err
);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO} state_t;
    state_t        state, state_nx;
    logic [6:0]    sync1, sync2;
    logic          e_d, fall;
    logic          stb, stb_rs, stb_rw, stb_busy;
    logic [3:0]    stb_db, hi;
    logic          hi_rs;
    logic [CW-1:0] cnt;
    logic          acc, pair_ok, addr_ok, exec, init_ok, is_long, bad;
    logic [7:0]    bval;
    logic [6:0]    addr_step;

    // Bus is {e, rs, rw, db}; the strobe stage registers the edge together with
    // the bus fields and the busy state seen when the edge was detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            e_d      <= 1'b0;
            stb      <= 1'b0;
            stb_rs   <= 1'b0;
            stb_rw   <= 1'b0;
            stb_db   <= '0;
            stb_busy <= 1'b0;
        end else begin
            sync1    <= {e, rs, rw, db};
            sync2    <= sync1;
            e_d      <= sync2[6];
            stb      <= fall;
            stb_rs   <= sync2[5];
            stb_rw   <= sync2[4];
            stb_db   <= sync2[3:0];
            stb_busy <= busy;
        end
    end

    assign fall    = !sync2[6] && e_d;
    assign busy    = cnt != '0;
    assign acc     = stb && !stb_rw;
    assign bval    = state == NIB_LO ? {hi, stb_db} : {stb_db, 4'h0};
    assign pair_ok = hi_rs == stb_rs;
    assign addr_ok = bval[6:0] <= 7'h27 || (bval[6:0] >= 7'h40 && bval[6:0] <= 7'h67);
    // DDRAM is two 40-character lines at 0x00 and 0x40; stepping wraps between them.
    assign addr_step = inc_mode
        ? (mem_addr == 7'h27 ? 7'h40 : mem_addr == 7'h67 ? 7'h00 : mem_addr + 7'd1)
        : (mem_addr == 7'h40 ? 7'h27 : mem_addr == 7'h00 ? 7'h67 : mem_addr - 7'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT8;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (acc) begin
            case (state)
                INIT8:   state_nx = init_ok ? NIB_HI : INIT8;
                NIB_HI:  state_nx = NIB_LO;
                default: state_nx = NIB_HI;
            endcase
        end
    end

    always_comb begin
        init_ok = bval == 8'h20 && !stb_rs;
        exec    = acc && state == NIB_LO && pair_ok;
        is_long = !stb_rs && bval[7:2] == 6'd0 && bval[1:0] != 2'd0;
        bad     = (stb && (stb_rw || stb_busy))
               || (acc && state == INIT8 && !init_ok && bval != 8'h30)
               || (acc && state == NIB_LO && !pair_ok)
               || (exec && !stb_rs && ((bval[7] && !addr_ok) || bval[7:4] == 4'b0011));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_valid <= 1'b0;
            byte_out   <= '0;
            byte_rs    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mode4      <= 1'b0;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            inc_mode   <= 1'b1;
            err        <= 1'b0;
            hi         <= '0;
            hi_rs      <= 1'b0;
            cnt        <= '0;
        end else begin
            byte_valid <= exec;
            mem_we     <= exec && stb_rs;
            cnt        <= busy ? cnt - CW'(1) : cnt;
            if (bad) err <= 1'b1;
            if (acc && state == NIB_HI) begin
                hi    <= stb_db;
                hi_rs <= stb_rs;
            end
            if (acc && state == INIT8 && init_ok) mode4 <= 1'b1;
            // Address advances the cycle after the write so mem_addr is valid alongside mem_we.
            if (mem_we) mem_addr <= addr_step;
            if (exec) begin
                byte_out <= bval;
                byte_rs  <= stb_rs;
                cnt      <= is_long ? CW'(CLEAR_CYCLES) : CW'(CMD_CYCLES);
                if (stb_rs) mem_data <= bval;
                else if (bval[7]) mem_addr <= bval[6:0];
                else if (bval[7:3] == 5'b00001) {disp_on, cursor_on, blink_on} <= bval[2:0];
                else if (bval[7:2] == 6'b000001) inc_mode <= bval[1];
                else if (bval[7:1] == 7'b0000001) mem_addr <= '0;
                else if (bval == 8'h01) begin
                    mem_addr <= '0;
                    inc_mode <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// tb_lcd_nibble_receiver: directed and randomized bench for lcd_nibble_receiver against a transaction-level model
module tb_lcd_nibble_receiver;
    localparam int CLR = 20;
    localparam int CMD = 5;

    logic       clk = 0, rst_n = 0, e = 0, rs = 0, rw = 0;
    logic [3:0] db = 0;
    logic       byte_valid, byte_rs, mem_we, mode4, disp_on, cursor_on, blink_on, inc_mode, busy, err;
    logic [7:0] byte_out, mem_data;
    logic [6:0] mem_addr;

    lcd_nibble_receiver #(.CLEAR_CYCLES(CLR), .CMD_CYCLES(CMD)) dut (
        .clk(clk), .rst_n(rst_n), .e(e), .rs(rs), .rw(rw), .db(db),
        .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mode4(mode4), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .inc_mode(inc_mode), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: protocol phase 0 = 8-bit init, 1 = expecting high nibble, 2 = expecting low nibble.
    int         m_phase, busy_until;
    bit         m_mode4, m_err, m_disp, m_cur, m_blink, m_inc, m_bv, m_we, m_brs, m_step, m_hi_rs;
    logic [3:0] m_hi;
    logic [7:0] m_bout, m_mdata;
    logic [6:0] m_addr;

    int bv_count = 0, we_count = 0, busy_len = 0;
    logic [6:0] we_addr = 0;
    logic [7:0] we_data = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; busy_until = 0;
        m_mode4 = 0; m_err = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1;
        m_bv = 0; m_we = 0; m_brs = 0; m_step = 0; m_hi_rs = 0;
        m_hi = 0; m_bout = 0; m_mdata = 0; m_addr = 0;
    endtask

    // Valid DDRAM addresses form one 80-entry ring: 0x00..0x27 then 0x40..0x67.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input bit inc);
        int idx;
        idx = a < 7'h40 ? int'(a) : int'(a) - 'h40 + 40;
        idx = (idx + (inc ? 1 : 79)) % 80;
        return idx < 40 ? 7'(idx) : 7'(idx - 40 + 'h40);
    endfunction

    task automatic exec(input bit r, input bit w, input logic [3:0] d);
        logic [7:0] b;
        if (w) begin
            m_err = 1;
            return;
        end
        if (cyc - 2 < busy_until) m_err = 1;
        if (m_phase == 0) begin
            b = {d, 4'h0};
            if (b == 8'h20 && !r) begin
                m_mode4 = 1;
                m_phase = 1;
            end else if (b != 8'h30) m_err = 1;
        end else if (m_phase == 1) begin
            m_hi = d; m_hi_rs = r; m_phase = 2;
        end else begin
            m_phase = 1;
            if (r != m_hi_rs) m_err = 1;
            else begin
                b = {m_hi, d};
                m_bv = 1; m_bout = b; m_brs = r;
                busy_until = cyc + CMD;
                if (r) begin
                    m_we = 1; m_mdata = b; m_step = 1;
                end else if (b == 8'h01) begin
                    m_addr = 0; m_inc = 1; busy_until = cyc + CLR;
                end else if (b == 8'h02 || b == 8'h03) begin
                    m_addr = 0; busy_until = cyc + CLR;
                end else if (b >= 8'h04 && b <= 8'h07) m_inc = b[1];
                else if (b >= 8'h08 && b <= 8'h0F) {m_disp, m_cur, m_blink} = b[2:0];
                else if (b >= 8'h30 && b <= 8'h3F) m_err = 1;
                else if (b >= 8'h80) begin
                    m_addr = b[6:0];
                    if (!(m_addr <= 7'h27 || (m_addr >= 7'h40 && m_addr <= 7'h67))) m_err = 1;
                end
            end
        end
    endtask

    task automatic post();
        m_bv = 0; m_we = 0;
        if (m_step) begin
            m_addr = step_addr(m_addr, m_inc);
            m_step = 0;
        end
    endtask

    task automatic run_model(input bit r, input bit w, input logic [3:0] d);
        repeat (4) @(posedge clk);
        #1 exec(r, w, d);
        @(posedge clk);
        #1 post();
    endtask

    task automatic strobe(input bit r, input bit w, input logic [3:0] d);
        @(negedge clk);
        rs = r; rw = w; db = d; e = 1;
        repeat (3) @(negedge clk);
        e = 0;
        run_model(r, w, d);
    endtask

    task automatic wait_idle();
        while (cyc < busy_until) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit r, input logic [7:0] b, input bit wt);
        strobe(r, 0, b[7:4]);
        strobe(r, 0, b[3:0]);
        if (wt) wait_idle();
    endtask

    task automatic init_seq();
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        model_reset();
        @(negedge clk);
        #2 rst_n = 1;
    endtask

    initial forever begin
        @(negedge clk);
        chk("byte_valid", byte_valid, m_bv);
        chk("byte_out", byte_out, m_bout);
        chk("byte_rs", byte_rs, m_brs);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data", mem_data, m_mdata);
        chk("mode4", mode4, m_mode4);
        chk("disp_on", disp_on, m_disp);
        chk("cursor_on", cursor_on, m_cur);
        chk("blink_on", blink_on, m_blink);
        chk("inc_mode", inc_mode, m_inc);
        chk("busy", busy, int'(cyc < busy_until));
        chk("err", err, m_err);
    end

    initial forever begin
        @(negedge clk);
        if (byte_valid) bv_count++;
        if (mem_we) begin
            we_count++; we_addr = mem_addr; we_data = mem_data;
        end
        if (byte_valid) busy_len = int'(busy);
        else if (busy) busy_len++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    int n_bv, n_we, k, idx;
    bit wt;
    logic [7:0] b;

    initial begin
        model_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        chk("rst_mode4", mode4, 0);
        chk("rst_inc_mode", inc_mode, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);

        init_seq();
        chk("init_mode4", mode4, 1);
        chk("init_err", err, 0);
        chk("init_no_byte_valid", bv_count, 0);

        send(0, 8'h0F, 1);
        chk("disp_on_0f", disp_on, 1);
        chk("cursor_on_0f", cursor_on, 1);
        chk("blink_on_0f", blink_on, 1);
        send(0, 8'h01, 1);
        repeat (3) @(posedge clk);
        chk("clear_busy_len", busy_len, 20);

        send(1, 8'h41, 1);
        chk("write_A_addr", we_addr, 8'h00);
        chk("write_A_data", we_data, 8'h41);
        chk("addr_after_A", mem_addr, 8'h01);

        send(0, 8'hA7, 1);
        send(1, 8'h58, 1);
        chk("wrap_inc_write_addr", we_addr, 8'h27);
        chk("wrap_inc_next", mem_addr, 8'h40);
        send(0, 8'h04, 1);
        send(1, 8'h59, 1);
        chk("wrap_dec_write_addr", we_addr, 8'h40);
        chk("wrap_dec_next", mem_addr, 8'h27);
        chk("err_before_busy_viol", err, 0);

        // 0x0C, then the next high nibble's E falls two cycles after byte_valid.
        strobe(0, 0, 4'h0);
        @(negedge clk);
        rs = 0; rw = 0; db = 4'hC; e = 1;
        repeat (3) @(negedge clk);
        e = 0;
        fork
            run_model(0, 0, 4'hC);
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                rs = 0; db = 4'h8; e = 1;
                repeat (3) @(negedge clk);
                e = 0;
            end
        join
        run_model(0, 0, 4'h8);
        strobe(0, 0, 4'h5);
        wait_idle();
        chk("busy_viol_err", err, 1);
        chk("busy_viol_byte", byte_out, 8'h85);
        chk("busy_viol_addr", mem_addr, 8'h05);
        chk("disp_0c", {disp_on, cursor_on, blink_on}, 3'b100);

        strobe(0, 0, 4'h8);
        @(negedge clk);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("midrst_mode4", mode4, 0);
        chk("midrst_err", err, 0);
        chk("midrst_disp", disp_on, 0);
        chk("midrst_byte_out", byte_out, 0);
        chk("midrst_inc", inc_mode, 1);
        @(negedge clk);
        #2 rst_n = 1;
        init_seq();
        chk("reinit_mode4", mode4, 1);
        chk("reinit_err", err, 0);
        send(1, 8'h42, 1);
        chk("reinit_write_addr", we_addr, 0);
        chk("reinit_write_data", we_data, 8'h42);

        n_bv = bv_count;
        strobe(0, 1, 4'h3);
        chk("rw_err", err, 1);
        chk("rw_no_byte_valid", bv_count, n_bv);

        do_reset();
        init_seq();
        n_bv = bv_count; n_we = we_count;
        strobe(1, 0, 4'h4);
        strobe(0, 0, 4'h1);
        chk("mismatch_err", err, 1);
        chk("mismatch_no_byte_valid", bv_count, n_bv);
        chk("mismatch_no_write", we_count, n_we);
        send(0, 8'h0E, 1);
        chk("after_mismatch_cursor", cursor_on, 1);

        do_reset();
        init_seq();
        send(0, 8'hE8, 1);
        chk("bad_ddram_err", err, 1);
        chk("bad_ddram_addr", mem_addr, 8'h68);

        do_reset();
        init_seq();
        for (int i = 0; i < 150; i++) begin
            k  = $urandom_range(0, 9);
            wt = $urandom_range(0, 3) != 0;
            case (k)
                0, 1, 2: send(1, 8'($urandom_range(32, 126)), wt);
                3: send(0, 8'h04 | 8'($urandom_range(0, 3)), wt);
                4: send(0, 8'h08 | 8'($urandom_range(0, 7)), wt);
                5: begin
                    idx = $urandom_range(0, 79);
                    b = 8'h80 | 8'(idx < 40 ? idx : idx + 24);
                    send(0, b, wt);
                end
                6: send(0, 8'($urandom_range(1, 3)), wt);
                7: send(0, 8'($urandom_range(16, 127)), wt);
                8: strobe($urandom_range(0, 1), 1, 4'($urandom_range(0, 15)));
                default: begin
                    strobe(1, 0, 4'($urandom_range(0, 15)));
                    strobe(0, 0, 4'($urandom_range(0, 15)));
                end
            endcase
        end
        wait_idle();
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
